fifo_tlp: RTL

//  Synchronous single-clock FIFO buffering TLP words between traffic classes and the arbiter.
//  One instance per virtual channel on each side of the arbiter:
//   - input side: the arbiter reads `empty` and drives `pop`.
//   - output side: the arbiter drives `push` and reads `almost_full`.

---
 rtl/fifo_tlp.sv | 69 ++++++
 1 files changed

// File: rtl/fifo_tlp.sv
// fifo_tlp: single-clock TLP word FIFO with registered read, programmable almost flags and sticky error.
// Ports: clk/reset (sync, active-high); push+data_in write; pop -> data_out/valid_out one cycle later;
// umbral_full/umbral_empty thresholds; count/full/empty/almost_full/almost_empty status; error sticky.
module fifo_tlp #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [ADDR_WIDTH:0]   umbral_full,
  input  logic [ADDR_WIDTH:0]   umbral_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d, error_q, error_d;
  logic                  push_ok, pop_ok;
  assign count        = count_q;
  assign full         = count_q == DEPTH;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= umbral_full;
  assign almost_empty = count_q <= umbral_empty;
  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign error        = error_q;
  always_comb begin
    pop_ok     = pop && !empty;
    // a full FIFO still takes a push when a pop frees the slot on the same edge
    push_ok    = push && (!full || pop_ok);
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push_ok);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(pop_ok);
    count_d    = count_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
    data_out_d = pop_ok ? mem[rd_ptr_q] : data_out_q;
    valid_d    = pop_ok;
    error_d    = error_q || (push && !push_ok) || (pop && !pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && push_ok) mem[wr_ptr_q] <= data_in;
endmodule
